// File: rtl/id_ex_pipe_if.sv
// rtl/id_ex_pipe_if.sv - ID-stage inputs and EX-stage register outputs of the ID/EX pipeline register
interface id_ex_pipe_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   Flush;
    logic                   RegWriteOut_ID, MemToReg_ID, R_Enable_ID, W_Enable_ID, RegDst_ID, ALUSrc0_ID;
    logic [1:0]             R_Width_ID, W_Width_ID, ALUSrc1_ID;
    logic [31:0]            Reg_Data1_ID, Reg_Data2_ID, Imm32b_ID, PCPlusFour_ID;
    logic [4:0]             Rs_ID, Rt_ID, Rd_ID;
    logic                   UsesRt_ID;

    logic                   RegWriteOut_EX, MemToReg_EX, R_Enable_EX, W_Enable_EX, RegDst_EX, ALUSrc0_EX;
    logic [1:0]             R_Width_EX, W_Width_EX, ALUSrc1_EX;
    logic [31:0]            Reg_Data1_EX, Reg_Data2_EX, Imm32b_EX, PCPlusFour_EX;
    logic [4:0]             Rs_EX, Rt_EX, Rd_EX;
    logic                   UsesRt_EX;
    logic [4:0]             Dest_EX;
    logic                   Stall_IF;
    logic [STALL_CNT_W-1:0] StallCount;

    modport master (
        output Flush, RegWriteOut_ID, MemToReg_ID, R_Enable_ID, W_Enable_ID, RegDst_ID, ALUSrc0_ID,
               R_Width_ID, W_Width_ID, ALUSrc1_ID, Reg_Data1_ID, Reg_Data2_ID, Imm32b_ID, PCPlusFour_ID,
               Rs_ID, Rt_ID, Rd_ID, UsesRt_ID,
        input  RegWriteOut_EX, MemToReg_EX, R_Enable_EX, W_Enable_EX, RegDst_EX, ALUSrc0_EX,
               R_Width_EX, W_Width_EX, ALUSrc1_EX, Reg_Data1_EX, Reg_Data2_EX, Imm32b_EX, PCPlusFour_EX,
               Rs_EX, Rt_EX, Rd_EX, UsesRt_EX, Dest_EX, Stall_IF, StallCount
    );

    modport slave (
        input  Flush, RegWriteOut_ID, MemToReg_ID, R_Enable_ID, W_Enable_ID, RegDst_ID, ALUSrc0_ID,
               R_Width_ID, W_Width_ID, ALUSrc1_ID, Reg_Data1_ID, Reg_Data2_ID, Imm32b_ID, PCPlusFour_ID,
               Rs_ID, Rt_ID, Rd_ID, UsesRt_ID,
        output RegWriteOut_EX, MemToReg_EX, R_Enable_EX, W_Enable_EX, RegDst_EX, ALUSrc0_EX,
               R_Width_EX, W_Width_EX, ALUSrc1_EX, Reg_Data1_EX, Reg_Data2_EX, Imm32b_EX, PCPlusFour_EX,
               Rs_EX, Rt_EX, Rd_EX, UsesRt_EX, Dest_EX, Stall_IF, StallCount
    );
endinterface

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with load-use bubble insertion and saturating stall counter
module id_ex_pipe #(
    parameter int STALL_CNT_W = 16
) (
    input logic          Clock,
    input logic          Reset,
    id_ex_pipe_if.slave  bus
);
    logic                   hazard;
    logic                   stall;
    logic                   squash;
    logic [STALL_CNT_W-1:0] stall_cnt;

    // A load in EX whose result the ID instruction needs is not ready until after EX.
    assign hazard = bus.R_Enable_EX & bus.RegWriteOut_EX & (bus.Dest_EX != 5'd0) &
                    ((bus.Dest_EX == bus.Rs_ID) | (bus.UsesRt_ID & (bus.Dest_EX == bus.Rt_ID)));
    assign stall  = hazard & ~bus.Flush;
    assign squash = ~Reset | bus.Flush | stall;

    assign bus.Stall_IF   = stall;
    assign bus.StallCount = stall_cnt;

    always_ff @(posedge Clock) begin
        if (squash) begin
            bus.RegWriteOut_EX <= 1'b0;
            bus.MemToReg_EX    <= 1'b0;
            bus.R_Enable_EX    <= 1'b0;
            bus.W_Enable_EX    <= 1'b0;
            bus.RegDst_EX      <= 1'b0;
            bus.ALUSrc0_EX     <= 1'b0;
            bus.R_Width_EX     <= 2'd0;
            bus.W_Width_EX     <= 2'd0;
            bus.ALUSrc1_EX     <= 2'd0;
            bus.Reg_Data1_EX   <= 32'd0;
            bus.Reg_Data2_EX   <= 32'd0;
            bus.Imm32b_EX      <= 32'd0;
            bus.PCPlusFour_EX  <= 32'd0;
            bus.Rs_EX          <= 5'd0;
            bus.Rt_EX          <= 5'd0;
            bus.Rd_EX          <= 5'd0;
            bus.UsesRt_EX      <= 1'b0;
            bus.Dest_EX        <= 5'd0;
        end else begin
            bus.RegWriteOut_EX <= bus.RegWriteOut_ID;
            bus.MemToReg_EX    <= bus.MemToReg_ID;
            bus.R_Enable_EX    <= bus.R_Enable_ID;
            bus.W_Enable_EX    <= bus.W_Enable_ID;
            bus.RegDst_EX      <= bus.RegDst_ID;
            bus.ALUSrc0_EX     <= bus.ALUSrc0_ID;
            bus.R_Width_EX     <= bus.R_Width_ID;
            bus.W_Width_EX     <= bus.W_Width_ID;
            bus.ALUSrc1_EX     <= bus.ALUSrc1_ID;
            bus.Reg_Data1_EX   <= bus.Reg_Data1_ID;
            bus.Reg_Data2_EX   <= bus.Reg_Data2_ID;
            bus.Imm32b_EX      <= bus.Imm32b_ID;
            bus.PCPlusFour_EX  <= bus.PCPlusFour_ID;
            bus.Rs_EX          <= bus.Rs_ID;
            bus.Rt_EX          <= bus.Rt_ID;
            bus.Rd_EX          <= bus.Rd_ID;
            bus.UsesRt_EX      <= bus.UsesRt_ID;
            bus.Dest_EX        <= bus.RegDst_ID ? bus.Rd_ID : bus.Rt_ID;
        end
    end

    // Counts inserted bubbles only; a flush never reaches here because stall already excludes it.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            stall_cnt <= '0;
        end else if (stall && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - randomized and directed bench for id_ex_pipe against a behavioural model
module tb_id_ex_pipe;
    typedef struct packed {
        logic        rw, m2r, ren, wen, rdst, as0;
        logic [1:0]  rwid, wwid, as1;
        logic [31:0] d1, d2, imm, pc;
        logic [4:0]  rs, rt, rd;
        logic        ut;
    } id_t;

    typedef struct packed {
        id_t        ins;
        logic [4:0] dest;
    } ex_t;

    logic Clock;
    logic Reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    ex_t         m_ex;
    int unsigned m_cnt16;
    int unsigned m_cnt2;

    id_ex_pipe_if #(.STALL_CNT_W(16)) if16 ();
    id_ex_pipe_if #(.STALL_CNT_W(2))  if2 ();

    id_ex_pipe #(.STALL_CNT_W(16)) dut16 (.Clock(Clock), .Reset(Reset), .bus(if16.slave));
    id_ex_pipe #(.STALL_CNT_W(2))  dut2  (.Clock(Clock), .Reset(Reset), .bus(if2.slave));

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic id_t mk(input logic ren, input logic rw, input logic rdst,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic ut);
        id_t r;
        r      = id_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
        r.ren  = ren;
        r.rw   = rw;
        r.rdst = rdst;
        r.rs   = rs;
        r.rt   = rt;
        r.rd   = rd;
        r.ut   = ut;
        return r;
    endfunction

    function automatic id_t rand_id();
        return mk($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom));
    endfunction

    task automatic drive(input id_t d, input logic fl);
        if16.Flush = fl;  if16.RegWriteOut_ID = d.rw;  if16.MemToReg_ID = d.m2r;
        if16.R_Enable_ID = d.ren;  if16.W_Enable_ID = d.wen;  if16.RegDst_ID = d.rdst;
        if16.ALUSrc0_ID = d.as0;  if16.R_Width_ID = d.rwid;  if16.W_Width_ID = d.wwid;
        if16.ALUSrc1_ID = d.as1;  if16.Reg_Data1_ID = d.d1;  if16.Reg_Data2_ID = d.d2;
        if16.Imm32b_ID = d.imm;  if16.PCPlusFour_ID = d.pc;  if16.Rs_ID = d.rs;
        if16.Rt_ID = d.rt;  if16.Rd_ID = d.rd;  if16.UsesRt_ID = d.ut;
        if2.Flush = fl;  if2.RegWriteOut_ID = d.rw;  if2.MemToReg_ID = d.m2r;
        if2.R_Enable_ID = d.ren;  if2.W_Enable_ID = d.wen;  if2.RegDst_ID = d.rdst;
        if2.ALUSrc0_ID = d.as0;  if2.R_Width_ID = d.rwid;  if2.W_Width_ID = d.wwid;
        if2.ALUSrc1_ID = d.as1;  if2.Reg_Data1_ID = d.d1;  if2.Reg_Data2_ID = d.d2;
        if2.Imm32b_ID = d.imm;  if2.PCPlusFour_ID = d.pc;  if2.Rs_ID = d.rs;
        if2.Rt_ID = d.rt;  if2.Rd_ID = d.rd;  if2.UsesRt_ID = d.ut;
    endtask

    // One cycle: apply ID inputs, check the combinational stall, clock, then check registered state.
    task automatic step(input id_t d, input logic fl, input logic rst_n);
        logic exp_stall;
        ex_t  obs16, obs2;
        drive(d, fl);
        Reset = rst_n;
        #1;
        exp_stall = m_ex.ins.ren && m_ex.ins.rw && (m_ex.dest != 0) &&
                    ((m_ex.dest == d.rs) || (d.ut && (m_ex.dest == d.rt))) && !fl;
        chk("stall_if", 160'(if16.Stall_IF), 160'(exp_stall));
        chk("stall_if_w2", 160'(if2.Stall_IF), 160'(exp_stall));

        if (!rst_n) begin
            m_ex    = '0;
            m_cnt16 = 0;
            m_cnt2  = 0;
        end else if (fl) begin
            m_ex = '0;
        end else if (exp_stall) begin
            m_ex    = '0;
            m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
            m_cnt2  = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        end else begin
            m_ex.ins  = d;
            m_ex.dest = d.rdst ? d.rd : d.rt;
        end

        @(posedge Clock);
        #1;
        obs16 = {if16.RegWriteOut_EX, if16.MemToReg_EX, if16.R_Enable_EX, if16.W_Enable_EX,
                 if16.RegDst_EX, if16.ALUSrc0_EX, if16.R_Width_EX, if16.W_Width_EX, if16.ALUSrc1_EX,
                 if16.Reg_Data1_EX, if16.Reg_Data2_EX, if16.Imm32b_EX, if16.PCPlusFour_EX,
                 if16.Rs_EX, if16.Rt_EX, if16.Rd_EX, if16.UsesRt_EX, if16.Dest_EX};
        obs2  = {if2.RegWriteOut_EX, if2.MemToReg_EX, if2.R_Enable_EX, if2.W_Enable_EX,
                 if2.RegDst_EX, if2.ALUSrc0_EX, if2.R_Width_EX, if2.W_Width_EX, if2.ALUSrc1_EX,
                 if2.Reg_Data1_EX, if2.Reg_Data2_EX, if2.Imm32b_EX, if2.PCPlusFour_EX,
                 if2.Rs_EX, if2.Rt_EX, if2.Rd_EX, if2.UsesRt_EX, if2.Dest_EX};
        chk("ex_regs", 160'(obs16), 160'(m_ex));
        chk("ex_regs_w2", 160'(obs2), 160'(m_ex));
        chk("stall_count", 160'(if16.StallCount), 160'(m_cnt16));
        chk("stall_count_w2", 160'(if2.StallCount), 160'(m_cnt2));
    endtask

    initial begin
        m_ex    = '0;
        m_cnt16 = 0;
        m_cnt2  = 0;
        Reset   = 1'b0;
        drive(rand_id(), 1'b0);
        @(posedge Clock);
        #1;

        step(rand_id(), 1'b0, 1'b0);
        step(rand_id(), 1'b1, 1'b0);

        // load-use through Rs: one bubble, then the held instruction loads
        step(mk(1, 1, 1, 5'd1, 5'd2, 5'd8, 0), 0, 1);
        step(mk(0, 1, 1, 5'd8, 5'd3, 5'd4, 0), 0, 1);
        step(mk(0, 1, 1, 5'd8, 5'd3, 5'd4, 0), 0, 1);

        // Rt dependency gated by UsesRt
        step(mk(1, 1, 0, 5'd1, 5'd9, 5'd7, 0), 0, 1);
        step(mk(0, 1, 1, 5'd1, 5'd9, 5'd4, 0), 0, 1);
        step(mk(1, 1, 0, 5'd1, 5'd9, 5'd7, 0), 0, 1);
        step(mk(0, 1, 1, 5'd1, 5'd9, 5'd4, 1), 0, 1);
        step(mk(0, 1, 1, 5'd1, 5'd9, 5'd4, 1), 0, 1);

        // hazard coinciding with flush
        step(mk(1, 1, 1, 5'd1, 5'd2, 5'd5, 0), 0, 1);
        step(mk(0, 1, 1, 5'd5, 5'd3, 5'd4, 0), 1, 1);

        // destination r0 and store in EX
        step(mk(1, 1, 1, 5'd1, 5'd2, 5'd0, 0), 0, 1);
        step(mk(0, 1, 1, 5'd0, 5'd0, 5'd4, 1), 0, 1);
        step(mk(0, 0, 1, 5'd1, 5'd2, 5'd6, 0), 0, 1);
        step(mk(0, 1, 1, 5'd6, 5'd6, 5'd4, 1), 0, 1);

        // back-to-back independent loads
        step(mk(1, 1, 1, 5'd1, 5'd2, 5'd10, 0), 0, 1);
        step(mk(1, 1, 1, 5'd11, 5'd12, 5'd13, 1), 0, 1);

        // saturation of the 2-bit counter over five load-use pairs after a reset
        step(rand_id(), 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(mk(1, 1, 1, 5'd1, 5'd2, 5'd20, 0), 0, 1);
            step(mk(0, 1, 1, 5'd20, 5'd3, 5'd4, 0), 0, 1);
            step(mk(0, 1, 1, 5'd20, 5'd3, 5'd4, 0), 0, 1);
        end

        // reset on the same edge as a pending bubble
        step(mk(1, 1, 1, 5'd1, 5'd2, 5'd15, 0), 0, 1);
        step(mk(0, 1, 1, 5'd15, 5'd3, 5'd4, 0), 0, 0);
        step(mk(1, 1, 1, 5'd15, 5'd3, 5'd4, 0), 0, 1);

        for (int i = 0; i < 400; i++) begin
            step(rand_id(), $urandom_range(0, 5) == 0, $urandom_range(0, 39) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 The block SHALL have one parameter: STALL_CNT_W, default 16, width of the load-use stall counter.
REQ-002 Clock  in  1  sole clock; all state updates on rising edge.
REQ-003 Reset  in  1  synchronous, active-low; sampled only on the rising edge of Clock.
REQ-004 Flush  in  1  branch taken; squash the instruction currently in ID.
REQ-005 RegWriteOut_ID, MemToReg_ID, R_Enable_ID, W_Enable_ID, RegDst_ID, ALUSrc0_ID  in  1 each  decode control signals.
REQ-006 R_Width_ID, W_Width_ID, ALUSrc1_ID  in  2 each  decode control fields.
REQ-007 Reg_Data1_ID, Reg_Data2_ID, Imm32b_ID, PCPlusFour_ID  in  32 each  decode data.
REQ-008 Rs_ID, Rt_ID, Rd_ID  in  5 each  register specifiers of the ID instruction.
REQ-009 UsesRt_ID  in  1  ID instruction reads Rt as a source.
REQ-010 Each *_ID control and data input SHALL have a matching registered *_EX output of the same width.
REQ-011 Dest_EX  out  5  registered destination register, equal to Rd_ID if RegDst_ID=1, else Rt_ID.
REQ-012 Stall_IF  out  1  combinational; hold PC and IF/ID this cycle.
REQ-013 StallCount  out  STALL_CNT_W  number of bubbles inserted since reset.

Function
REQ-014 Each cycle the block SHALL take exactly one action, by priority: Reset > Flush > Bubble > Load.
REQ-015 Load: all *_EX outputs and Dest_EX SHALL capture their ID values; latency is 1 cycle.
REQ-016 Hazard SHALL be defined as R_Enable_EX & RegWriteOut_EX & (Dest_EX != 0) & ((Dest_EX == Rs_ID) | (UsesRt_ID & (Dest_EX == Rt_ID))).
REQ-017 Stall_IF SHALL equal Hazard & ~Flush, computed combinationally from the registered EX state and the current ID inputs.
REQ-018 Bubble (Stall_IF=1): all *_EX outputs and Dest_EX SHALL load 0 on the next edge.
REQ-019 Bubble: StallCount SHALL increment by 1 and saturate at all-ones (no wrap).
REQ-020 Flush: all *_EX outputs and Dest_EX SHALL load 0; StallCount SHALL be unchanged; Stall_IF SHALL be 0 even if Hazard=1.
REQ-021 A bubble SHALL self-clear: after a bubble, R_Enable_EX=0, so Hazard=0 next cycle and the held instruction loads on the following edge (exactly 1 stall cycle per load-use).
REQ-022 Back-to-back loads with no dependency SHALL NOT stall.
REQ-023 Destination register 0 SHALL never cause a stall.
REQ-024 A store (W_Enable_EX=1, RegWriteOut_EX=0) in EX SHALL never cause a stall.
REQ-025 The block SHALL contain no forwarding logic.

Reset
REQ-026 With Reset=0 at an edge, all *_EX outputs, Dest_EX and StallCount SHALL become 0; Stall_IF SHALL evaluate to 0 on the following cycle.
REQ-027 Reset asserted mid-stall SHALL discard the pending bubble; no counter increment occurs on that edge.
REQ-028 Reset SHALL override a simultaneous Flush or Hazard.

Verification
REQ-029 Load-use: EX holds lw (R_Enable=1, RegWriteOut=1, Dest=8); ID has Rs=8 -> Stall_IF=1, next edge EX all-zero, StallCount=1; following edge ID values captured.
REQ-030 Rt dependency: EX lw to r9; ID Rt=9 with UsesRt=0 -> no stall; the same case with UsesRt=1 -> one bubble.
REQ-031 Hazard plus Flush in the same cycle: EX lw to r5, ID Rs=5, Flush=1 -> Stall_IF=0, EX zeroed, StallCount unchanged.
REQ-032 Zero register: EX lw with Dest=0, ID Rs=0 -> Stall_IF=0, normal load.
REQ-033 Saturation: STALL_CNT_W=2 with 5 load-use pairs -> StallCount sequence 1, 2, 3, 3, 3.
REQ-034 Mid-stall reset: Stall_IF=1 with Reset=0 at the same edge -> all outputs 0, StallCount=0, then normal loading after Reset=1.
